// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback source encodings, register-file
// geometry defaults and the commit predicate used by the W stage.
package pipe_pkg;

    localparam int DW   = 32;
    localparam int NREG = 32;

    localparam logic [2:0] WDS_ALU  = 3'd0;
    localparam logic [2:0] WDS_DM   = 3'd1;
    localparam logic [2:0] WDS_PC8  = 3'd2;
    localparam logic [2:0] WDS_EXT  = 3'd3;
    localparam logic [2:0] WDS_MUDI = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A write retires only with a real destination and a legal source.
    function automatic logic commit_ok(input logic       we,
                                       input logic [4:0] a3,
                                       input logic [2:0] wd_sel);
        return we && (a3 != REG_ZERO) && (wd_sel <= WDS_MUDI);
    endfunction

endpackage

// File: rtl/grf_writeback_if.sv
// W-stage writeback / D-stage read bus for the general register file.
// master: pipeline side driving the W and D stage inputs.
// slave:  the register file (grf_writeback).
interface grf_writeback_if;

    logic                    WE_W;
    logic [4:0]              A3_W;
    logic [2:0]              WD_SEL_W;
    logic [pipe_pkg::DW-1:0] ALU_OUT_W;
    logic [pipe_pkg::DW-1:0] DM_OUT_W;
    logic [pipe_pkg::DW-1:0] EXT_OUT_W;
    logic [pipe_pkg::DW-1:0] MUDI_OUT_W;
    logic [pipe_pkg::DW-1:0] PC_W;
    logic [4:0]              A1_D;
    logic [4:0]              A2_D;
    logic [pipe_pkg::DW-1:0] RD1_D;
    logic [pipe_pkg::DW-1:0] RD2_D;
    logic [pipe_pkg::DW-1:0] WD_W;
    logic [pipe_pkg::DW-1:0] commit_cnt;
    logic [pipe_pkg::DW-1:0] last_pc;
    logic                    sel_err;

    modport master (
        output WE_W, A3_W, WD_SEL_W, ALU_OUT_W, DM_OUT_W, EXT_OUT_W,
               MUDI_OUT_W, PC_W, A1_D, A2_D,
        input  RD1_D, RD2_D, WD_W, commit_cnt, last_pc, sel_err
    );

    modport slave (
        input  WE_W, A3_W, WD_SEL_W, ALU_OUT_W, DM_OUT_W, EXT_OUT_W,
               MUDI_OUT_W, PC_W, A1_D, A2_D,
        output RD1_D, RD2_D, WD_W, commit_cnt, last_pc, sel_err
    );

endinterface

// File: rtl/wb_sel_mux.sv
// Writeback source select: picks the W-stage result and flags encodings
// outside the defined set (those produce zero).
module wb_sel_mux
    import pipe_pkg::*;
#(
    parameter int DW     = pipe_pkg::DW,
    parameter int PC_OFS = 8
) (
    input  logic [2:0]    sel,
    input  logic [DW-1:0] alu,
    input  logic [DW-1:0] dm,
    input  logic [DW-1:0] ext,
    input  logic [DW-1:0] mudi,
    input  logic [DW-1:0] pc,
    output logic [DW-1:0] wd,
    output logic          illegal
);

    // Decode the source select; link writes store PC plus the link offset.
    always_comb begin
        wd      = '0;
        illegal = 1'b0;
        case (sel)
            WDS_ALU:  wd = alu;
            WDS_DM:   wd = dm;
            WDS_PC8:  wd = pc + DW'(PC_OFS);
            WDS_EXT:  wd = ext;
            WDS_MUDI: wd = mudi;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/grf_writeback.sv
// W-stage general register file: writeback select, 32x32 array with r0
// hardwired to zero, two combinational D-stage read ports, plus debug
// state (retired-write count, PC of last retired write, sticky bad-select).
// Build option: define GRF_BYPASS_EN to forward a same-cycle write to the
// read ports; without it reads return the pre-write array contents.
module grf_writeback #(
    parameter int NREG   = pipe_pkg::NREG,
    parameter int DW     = pipe_pkg::DW,
    parameter int PC_OFS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    grf_writeback_if.slave bus
);
    import pipe_pkg::*;

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] last_pc_q;
    logic          sel_err_q;
    logic [DW-1:0] wd;
    logic          sel_illegal;
    logic          commit;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    wb_sel_mux #(.DW(DW), .PC_OFS(PC_OFS)) u_sel (
        .sel     (bus.WD_SEL_W),
        .alu     (bus.ALU_OUT_W),
        .dm      (bus.DM_OUT_W),
        .ext     (bus.EXT_OUT_W),
        .mudi    (bus.MUDI_OUT_W),
        .pc      (bus.PC_W),
        .wd      (wd),
        .illegal (sel_illegal)
    );

    assign commit = commit_ok(bus.WE_W, bus.A3_W, bus.WD_SEL_W);

    // Register array update; r0 is never written because commit excludes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (commit) begin
            rf_q[bus.A3_W] <= wd;
        end
    end

    // Debug state: retired-write counter, last committed PC, sticky bad select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            last_pc_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            if (commit) begin
                cnt_q     <= cnt_q + DW'(1);
                last_pc_q <= bus.PC_W;
            end
            if (bus.WE_W && sel_illegal) sel_err_q <= 1'b1;
        end
    end

    // Read ports; a matching address with a commit in flight implies a nonzero address.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bus.A1_D != REG_ZERO) rd1 = rf_q[bus.A1_D];
        if (bus.A2_D != REG_ZERO) rd2 = rf_q[bus.A2_D];
`ifdef GRF_BYPASS_EN
        if (commit && (bus.A1_D == bus.A3_W)) rd1 = wd;
        if (commit && (bus.A2_D == bus.A3_W)) rd2 = wd;
`endif
    end

    assign bus.RD1_D      = rd1;
    assign bus.RD2_D      = rd2;
    assign bus.WD_W       = wd;
    assign bus.commit_cnt = cnt_q;
    assign bus.last_pc    = last_pc_q;
    assign bus.sel_err    = sel_err_q;

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- W-stage consumer of the M/W pipeline register. It selects the writeback value, writes the 32x32 general register file, and serves the two D-stage read ports.
- It sits between the M/W register outputs and the D-stage operand fetch / forwarding muxes.
- It also keeps a retired-write counter and the PC of the last committed write, for debug visibility.

Parameters:
- NREG, 32, number of architectural registers (register 0 hardwired to zero)
- DW, 32, data width
- PC_OFS, 8, offset added to PC_W for link writes (jal/jalr)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- WE_W  in  1  W-stage write enable
- A3_W  in  5  destination register
- WD_SEL_W  in  3  writeback source select
- ALU_OUT_W  in  32  ALU result
- DM_OUT_W  in  32  data-memory load result
- EXT_OUT_W  in  32  extender result (lui)
- MUDI_OUT_W  in  32  mult/div HI/LO read result
- PC_W  in  32  W-stage instruction PC
- A1_D  in  5  D-stage read address 1
- A2_D  in  5  D-stage read address 2
- RD1_D  out  32  read data 1
- RD2_D  out  32  read data 2
- WD_W  out  32  selected writeback value (combinational), for forwarding into D/E/M
- commit_cnt  out  32  count of committed register writes
- last_pc  out  32  PC_W of the most recent committed write
- sel_err  out  1  sticky flag: illegal WD_SEL_W seen with WE_W=1

Behaviour:
- Reset: while rst_n=0, asynchronously clear all registers, commit_cnt, last_pc and sel_err to 0. Reset asserted mid-write cancels that write.
- WD_SEL_W decode:
  - 0: ALU_OUT_W
  - 1: DM_OUT_W
  - 2: PC_W+PC_OFS, modulo 2^32
  - 3: EXT_OUT_W
  - 4: MUDI_OUT_W
  - 5..7: WD_W=0; treated as illegal.
- Commit condition: WE_W=1, A3_W!=0 and WD_SEL_W<=4.
- On a commit at the posedge:
  - reg[A3_W] <= WD_W
  - commit_cnt <= commit_cnt+1, wrapping from 0xFFFFFFFF to 0
  - last_pc <= PC_W
- Writes with A3_W=0 are dropped: no state change, counter not incremented.
- If WE_W=1 and WD_SEL_W>4: no write, and sel_err <= 1. sel_err stays set until reset.
- WE_W=0: no state change regardless of the other inputs.
- Reads are combinational from the array. Address 0 always returns 0.
- Read/write same cycle, same address: behaviour is set by GRF_BYPASS_EN (see Optional Feature).
- Both read ports may address the same register, and each returns identical data.
- Latency:
  - write visible one cycle after commit without bypass, same cycle with bypass.
  - commit_cnt and last_pc update one cycle after commit.

Optional Feature:
- Macro GRF_BYPASS_EN, compiled in:
  - if a commit is pending this cycle with A3_W==A1_D (resp. A2_D) and A3_W!=0, then RD1_D (resp. RD2_D) = WD_W (write-through).
- Macro GRF_BYPASS_EN, compiled out:
  - reads return the pre-write array value; the external hazard unit must forward from W.

Decomposition:
- Shared package pipe_pkg holds:
  - WD_SEL encodings: WDS_ALU=0, WDS_DM=1, WDS_PC8=2, WDS_EXT=3, WDS_MUDI=4
  - REG_ZERO=0
  - DW and NREG defaults
- Package function holds the commit predicate (WE, A3, WD_SEL -> commit).
- One natural sub-module, wb_sel_mux: the combinational WD_SEL_W decode producing WD_W and the illegal flag. The array and counters stay in grf_writeback.

Test Plan:
- Reset: drive rst_n=0 mid-run with writes pending -> RD1_D/RD2_D=0 for all addresses, commit_cnt=0, last_pc=0, sel_err=0; asserted asynchronously, without waiting for clk.
- Basic write/read: WE_W=1, A3_W=5, WD_SEL_W=0, ALU_OUT_W=0x1234_5678 -> next cycle A1_D=5 reads 0x12345678, commit_cnt=1, last_pc=PC_W.
- Source select: jal with WD_SEL_W=2, PC_W=0x0000_3000, A3_W=31 -> reg31=0x0000_3008. Repeat for selects 1, 3, 4 with distinct values and confirm each lands in its target register.
- Zero register: WE_W=1, A3_W=0, ALU_OUT_W=0xFFFF_FFFF -> A1_D=0 reads 0 and commit_cnt is unchanged.
- Illegal select: WE_W=1, A3_W=7, WD_SEL_W=6 -> reg7 unchanged, sel_err=1 and stays 1 after later legal writes.
- Same-cycle hazard: A3_W=A1_D=A2_D=9, reg9=0x11, write of 0x22 -> RD1_D=RD2_D=0x22 with GRF_BYPASS_EN defined, 0x11 without it. Also force commit_cnt to 0xFFFF_FFFF, commit once -> commit_cnt wraps to 0.
